// File: rtl/alu16_seq_pkg.sv
// Shared types and ALU control encodings for the 16-bit arithmetic sequencer.
package alu16_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD16 = 2'd0,
    OP_SUB16 = 2'd1,
    OP_INC16 = 2'd2,
    OP_DEC16 = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    CARRY = 3'd2,
    HI    = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_LT  = 4'd7;
  localparam logic [3:0] ALU_EQ  = 4'd8;
  localparam logic [3:0] ALU_INC = 4'd11;
  localparam logic [3:0] ALU_DEC = 4'd12;

endpackage

// File: rtl/alu16_sequencer.sv
// Multi-cycle 16-bit ADD/SUB/INC/DEC built on a shared 8-bit ALU without carry;
// the carry/borrow is recovered with compare ops and applied as a high-byte fix-up.
module alu16_sequencer
  import alu16_seq_pkg::*;
#(
  parameter int unsigned CONST_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        busy,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cntr,
  input  logic [7:0]  alu_result
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [15:0] a_q, b_q;
  logic [7:0]  res_lo_q, res_hi_q;
  logic        carry_q;
  logic        resp_valid_q;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = {res_hi_q, res_lo_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = LO;
      LO:      state_d = CARRY;
      CARRY:   state_d = HI;
      HI:      state_d = (carry_q || (CONST_LATENCY != 0)) ? FIX : DONE;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Carry out of the low byte: a sum that wrapped is smaller than an addend,
  // a borrow happens exactly when the minuend is smaller than the subtrahend.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_cntr = ALU_ADD;
    case (state_q)
      LO: begin
        alu_a = a_q[7:0];
        case (op_q)
          OP_ADD16: begin alu_b = b_q[7:0]; alu_cntr = ALU_ADD; end
          OP_SUB16: begin alu_b = b_q[7:0]; alu_cntr = ALU_SUB; end
          OP_INC16: alu_cntr = ALU_INC;
          default:  alu_cntr = ALU_DEC;
        endcase
      end
      CARRY: begin
        case (op_q)
          OP_ADD16: begin alu_a = res_lo_q; alu_b = a_q[7:0]; alu_cntr = ALU_LT; end
          OP_SUB16: begin alu_a = a_q[7:0]; alu_b = b_q[7:0]; alu_cntr = ALU_LT; end
          OP_INC16: begin alu_a = res_lo_q; alu_cntr = ALU_EQ; end
          default:  begin alu_a = a_q[7:0]; alu_cntr = ALU_EQ; end
        endcase
      end
      HI: begin
        alu_a = a_q[15:8];
        case (op_q)
          OP_ADD16: begin alu_b = b_q[15:8]; alu_cntr = ALU_ADD; end
          OP_SUB16: begin alu_b = b_q[15:8]; alu_cntr = ALU_SUB; end
          default:  alu_cntr = ALU_ADD;
        endcase
      end
      FIX: begin
        alu_a = res_hi_q;
        if (!carry_q)
          alu_cntr = ALU_ADD;
        else if (op_q == OP_ADD16 || op_q == OP_INC16)
          alu_cntr = ALU_INC;
        else
          alu_cntr = ALU_DEC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_ADD16;
      a_q          <= '0;
      b_q          <= '0;
      res_lo_q     <= '0;
      res_hi_q     <= '0;
      carry_q      <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: if (req_valid) begin
          op_q <= op_e'(req_op);
          a_q  <= req_a;
          b_q  <= req_b;
        end
        LO:      res_lo_q <= alu_result;
        CARRY:   carry_q  <= alu_result[0];
        HI:      res_hi_q <= alu_result;
        FIX:     res_hi_q <= alu_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Bench for alu16_sequencer: two instances (variable and constant latency) share
// stimulus, each paired with a behavioural 8-bit ALU and a per-cycle reference model.
module tb_alu16_sequencer;
  import alu16_seq_pkg::*;

  logic        clk, reset, req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_a, req_b;

  logic        rdy0, rv0, bsy0, rdy1, rv1, bsy1;
  logic [15:0] rd0, rd1;
  logic [7:0]  aa0, ab0, ar0, aa1, ab1, ar1;
  logic [3:0]  ac0, ac1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  alu16_sequencer #(.CONST_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(rv0),
    .resp_data(rd0), .busy(bsy0), .alu_a(aa0), .alu_b(ab0),
    .alu_cntr(ac0), .alu_result(ar0));

  alu16_sequencer #(.CONST_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(rv1),
    .resp_data(rd1), .busy(bsy1), .alu_a(aa1), .alu_b(ab1),
    .alu_cntr(ac1), .alu_result(ar1));

  function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_LT:  return {7'd0, a < b};
      ALU_EQ:  return {7'd0, a == b};
      ALU_INC: return a + 8'd1;
      ALU_DEC: return a - 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  always_comb ar0 = alu_f(ac0, aa0, ab0);
  always_comb ar1 = alu_f(ac1, aa1, ab1);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (actual=running required=finished)");
    $fatal(1);
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", nm, k, cyc, act, exp);
    end
  endtask

  // Reference model: one in-flight operation per instance, timed by cycles since accept.
  bit          m_busy[2];
  int          m_acc[2];
  logic [15:0] m_res[2], m_last[2], m_a[2];
  logic [1:0]  m_op[2];
  bit          m_fix[2];
  int          acc_cnt[2];
  bit          started = 0;

  function automatic logic [3:0] exp_cntr(input logic [1:0] op, input int ph, input bit fix);
    case (ph)
      1: return (op == 0) ? ALU_ADD : (op == 1) ? ALU_SUB : (op == 2) ? ALU_INC : ALU_DEC;
      2: return (op < 2) ? ALU_LT : ALU_EQ;
      3: return (op == 1) ? ALU_SUB : ALU_ADD;
      4: return fix ? ((op == 0 || op == 2) ? ALU_INC : ALU_DEC) : ALU_ADD;
      default: return ALU_ADD;
    endcase
  endfunction

  task automatic check_inst(input int k, input int cl, input logic rv, input logic [15:0] rd,
                            input logic rdy, input logic bsy, input logic [3:0] cn,
                            input logic [7:0] aa, input logic [7:0] ab);
    bit wb;
    int ph, dph;
    wb  = m_busy[k];
    ph  = cyc - m_acc[k];
    dph = 4 + ((m_fix[k] || cl != 0) ? 1 : 0);
    if (started) begin
      chk("req_ready", k, 32'(rdy), 32'(!wb));
      chk("busy", k, 32'(bsy), 32'(wb));
      chk("resp_valid", k, 32'(rv), 32'(wb && ph == dph));
      if (wb && ph == dph)        chk("resp_data", k, 32'(rd), 32'(m_res[k]));
      else if (!wb || ph == 1)    chk("resp_data_hold", k, 32'(rd), 32'(m_last[k]));
      chk("alu_cntr", k, 32'(cn), 32'(wb ? exp_cntr(m_op[k], ph, m_fix[k]) : ALU_ADD));
      if (!wb || ph == dph) begin
        chk("alu_a_idle", k, 32'(aa), 32'd0);
        chk("alu_b_idle", k, 32'(ab), 32'd0);
      end else if (ph == 1) begin
        chk("alu_a_lo", k, 32'(aa), 32'(m_a[k][7:0]));
      end
    end
    if (reset) begin
      m_busy[k] = 0;
      m_last[k] = 16'h0000;
    end else if (wb) begin
      if (ph == dph) begin
        m_busy[k] = 0;
        m_last[k] = m_res[k];
      end
    end else if (req_valid) begin
      m_busy[k] = 1;
      m_acc[k]  = cyc;
      m_op[k]   = req_op;
      m_a[k]    = req_a;
      acc_cnt[k]++;
      case (req_op)
        2'd0: begin m_res[k] = req_a + req_b;  m_fix[k] = (9'(req_a[7:0]) + 9'(req_b[7:0])) > 9'd255; end
        2'd1: begin m_res[k] = req_a - req_b;  m_fix[k] = req_a[7:0] < req_b[7:0]; end
        2'd2: begin m_res[k] = req_a + 16'd1;  m_fix[k] = req_a[7:0] == 8'hFF; end
        default: begin m_res[k] = req_a - 16'd1; m_fix[k] = req_a[7:0] == 8'h00; end
      endcase
    end
  endtask

  always @(negedge clk) begin
    check_inst(0, 0, rv0, rd0, rdy0, bsy0, ac0, aa0, ab0);
    check_inst(1, 1, rv1, rd1, rdy1, bsy1, ac1, aa1, ab1);
    if (reset) started = 1;
  end

  // Directed operation with literal expectations for data, latency and the
  // instance-0 ALU control sequence over the first four post-accept cycles.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_d, input int exp_l0, input int exp_l1, input logic [15:0] exp_seq);
    int l0, l1;
    logic [15:0] d0, d1, seq;
    l0 = 0; l1 = 0; d0 = '0; d1 = '0; seq = '0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = 16'(~a);
      if (i <= 4) seq = {seq[11:0], ac0};
      if (rv0 && l0 == 0) begin l0 = i; d0 = rd0; end
      if (rv1 && l1 == 0) begin l1 = i; d1 = rd1; end
    end
    chk({nm, "_data0"}, 0, 32'(d0), 32'(exp_d));
    chk({nm, "_data1"}, 1, 32'(d1), 32'(exp_d));
    chk({nm, "_lat0"}, 0, 32'(l0), 32'(exp_l0));
    chk({nm, "_lat1"}, 1, 32'(l1), 32'(exp_l1));
    chk({nm, "_cntrseq"}, 0, 32'(seq), 32'(exp_seq));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 0, 32'(rd0), 32'h0);
    chk("reset_valid", 0, 32'(rv0), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 0, 32'(rdy0), 32'h1);

    run_op("add_carry", 2'd0, 16'h12FF, 16'h0001, 16'h1300, 5, 5, 16'h070B);
    run_op("add_nocarry", 2'd0, 16'h1234, 16'h0101, 16'h1335, 4, 5, 16'h0700);
    run_op("sub_borrow", 2'd1, 16'h1000, 16'h0001, 16'h0FFF, 5, 5, 16'h171C);
    run_op("sub_wrap", 2'd1, 16'h0000, 16'h0001, 16'hFFFF, 5, 5, 16'h171C);
    run_op("inc_wrap", 2'd2, 16'hFFFF, 16'h1234, 16'h0000, 5, 5, 16'hB80B);
    run_op("dec_wrap", 2'd3, 16'h0000, 16'h5678, 16'hFFFF, 5, 5, 16'hC80C);
    run_op("inc_nofix", 2'd2, 16'h00FE, 16'h0000, 16'h00FF, 4, 5, 16'hB800);

    // Held request with changing operands: only the idle-cycle samples are taken.
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    req_valid = 1'b1; req_op = 2'd0; req_b = 16'h0101;
    for (int i = 0; i < 10; i++) begin
      req_a = 16'h1000 + 16'(i * 16'h0111);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("hold_accepts", 0, 32'(acc_cnt[0]), 32'd2);
    chk("hold_accepts", 1, 32'(acc_cnt[1]), 32'd2);

    // Reset during the CARRY cycle aborts the operation.
    req_valid = 1'b1; req_op = 2'd0; req_a = 16'h12FF; req_b = 16'h0001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_data", 0, 32'(rd0), 32'h0);
    chk("abort_ready", 0, 32'(rdy0), 32'h1);
    chk("abort_valid", 0, 32'(rv0), 32'h0);
    repeat (6) @(posedge clk);
    #1;
    run_op("inc_after_abort", 2'd2, 16'h0041, 16'h0000, 16'h0042, 4, 5, 16'hB800);

    // Randomized traffic with edge-biased low bytes and occasional reset.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 2'($urandom_range(0, 3));
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      case ($urandom_range(0, 3))
        0: req_a[7:0] = 8'hFF;
        1: req_a[7:0] = 8'h00;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) req_b[7:0] = req_a[7:0];
      reset = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
